// File: rtl/popcount_ternary_seq_if.sv
// Handshake and data bundle for popcount_ternary_seq.
// The master side offers transactions and consumes results; the slave side
// is the popcount controller.
interface popcount_ternary_seq_if #(
  parameter int N_IN = 9
);
  localparam int CW = $clog2(N_IN + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN-1:0]      in_pos;
  logic [N_IN-1:0]      in_neg;
  logic signed [CW:0]   thresh;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [CW:0]   out_diff;
  logic                 out_fire;
  logic                 busy;

  modport master (
    output in_valid, in_pos, in_neg, thresh, out_ready,
    input  in_ready, out_valid, out_diff, out_fire, busy
  );

  modport slave (
    input  in_valid, in_pos, in_neg, thresh, out_ready,
    output in_ready, out_valid, out_diff, out_fire, busy
  );
endinterface

// File: rtl/popcount_ternary_seq.sv
// Ternary neuron evaluator: time-shares one 3-input popcount slice over the
// positive and negative match vectors (3 bits per cycle) and reports
// pos_count - neg_count. Optional threshold compare is enabled by defining
// POPCNT_TERN_THRESH_EN; without it out_fire is tied low and thresh is ignored.
module popcount_ternary_seq #(
  parameter int N_IN = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  popcount_ternary_seq_if.slave bus
);
  localparam int K  = (N_IN + 2) / 3;
  localparam int CW = $clog2(N_IN + 1);
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 3 * K;

  typedef enum logic [1:0] {S_IDLE, S_POS, S_NEG, S_DONE} state_t;

  state_t             state_q;
  logic [IW-1:0]      idx_q;
  logic [PW-1:0]      pos_q, neg_q;
  logic [CW-1:0]      acc_pos_q, acc_neg_q;
  logic signed [CW:0] diff_q;
  logic               fire_q;
  logic               in_ready_q, out_valid_q, busy_q;

  // Vectors are shifted right as they are consumed, so the active chunk is
  // always the low 3 bits; zero padding at the MSB end fills in naturally.
  logic [2:0]         chunk;
  logic [1:0]         cnt;
  logic [CW-1:0]      acc_neg_fin;
  logic signed [CW:0] diff_fin;
  logic               last;

  // Shared full-adder slice plus the final subtract used on the last NEG cycle
  always_comb begin
    chunk       = (state_q == S_NEG) ? neg_q[2:0] : pos_q[2:0];
    cnt         = {(chunk[0] & chunk[1]) | (chunk[0] & chunk[2]) | (chunk[1] & chunk[2]),
                   ^chunk};
    acc_neg_fin = acc_neg_q + CW'(cnt);
    diff_fin    = $signed({1'b0, acc_pos_q}) - $signed({1'b0, acc_neg_fin});
    last        = (idx_q == IW'(K - 1));
  end

`ifdef POPCNT_TERN_THRESH_EN
  logic signed [CW:0] thr_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^bus.thresh;
`endif

  // Controller FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      pos_q       <= '0;
      neg_q       <= '0;
      acc_pos_q   <= '0;
      acc_neg_q   <= '0;
      diff_q      <= '0;
      fire_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef POPCNT_TERN_THRESH_EN
      thr_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            pos_q      <= PW'(bus.in_pos);
            neg_q      <= PW'(bus.in_neg);
`ifdef POPCNT_TERN_THRESH_EN
            thr_q      <= bus.thresh;
`endif
            acc_pos_q  <= '0;
            acc_neg_q  <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_POS;
          end
        end
        S_POS: begin
          acc_pos_q <= acc_pos_q + CW'(cnt);
          pos_q     <= pos_q >> 3;
          if (last) begin
            idx_q   <= '0;
            state_q <= S_NEG;
          end else begin
            idx_q   <= idx_q + 1'b1;
          end
        end
        S_NEG: begin
          acc_neg_q <= acc_neg_fin;
          neg_q     <= neg_q >> 3;
          if (last) begin
            idx_q       <= '0;
            diff_q      <= diff_fin;
`ifdef POPCNT_TERN_THRESH_EN
            fire_q      <= (diff_fin >= thr_q);
`endif
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q       <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          // Result stays put until the consumer takes it
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_diff  = diff_q;
  assign bus.busy      = busy_q;
`ifdef POPCNT_TERN_THRESH_EN
  assign bus.out_fire  = fire_q;
`else
  assign bus.out_fire  = 1'b0;
  logic unused_fire;
  assign unused_fire = fire_q;
`endif

endmodule

// File: tb/tb_popcount_ternary_seq.sv
// Bench for popcount_ternary_seq: scoreboard of popcount differences checked
// every cycle the result is valid, plus directed literal expectations.
module tb_popcount_ternary_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  popcount_ternary_seq_if #(.N_IN(9))  bus ();
  popcount_ternary_seq_if #(.N_IN(10)) bus10 ();

  popcount_ternary_seq #(.N_IN(9))  dut   (.clk(clk), .rst(rst), .bus(bus));
  popcount_ternary_seq #(.N_IN(10)) dut10 (.clk(clk), .rst(rst), .bus(bus10));

`ifdef POPCNT_TERN_THRESH_EN
  localparam bit FIRE_EN = 1'b1;
`else
  localparam bit FIRE_EN = 1'b0;
`endif

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  typedef struct {
    int diff;
    bit fire;
    int acc;
  } exp_t;

  exp_t sbq[$];
  int   rise_cyc[$];
  bit   ov_d = 1'b0;

  function automatic exp_t model(logic [8:0] p, logic [8:0] n, logic signed [4:0] t, int c);
    exp_t e;
    e.diff = $countones(p) - $countones(n);
    e.fire = FIRE_EN && (e.diff >= int'(t));
    e.acc  = c;
    return e;
  endfunction

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Acceptance/consumption monitor on the active edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) sbq.delete();
    else begin
      if (bus.out_valid && bus.out_ready && sbq.size() > 0) void'(sbq.pop_front());
      if (bus.in_valid && bus.in_ready)
        sbq.push_back(model(bus.in_pos, bus.in_neg, bus.thresh, cyc + 1));
    end
  end

  // Compare process: every valid cycle against the scoreboard head
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", int'(bus.out_valid), 0);
    end else if (bus.out_valid) begin
      if (sbq.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        chk("sb_diff", int'(bus.out_diff), sbq[0].diff);
        chk("sb_fire", int'(bus.out_fire), int'(sbq[0].fire));
        if (!ov_d) begin
          chk("sb_latency", cyc - sbq[0].acc, 6);
          rise_cyc.push_back(cyc);
        end
      end
    end
    ov_d = bus.out_valid && !rst;
  end

  task automatic send(logic [8:0] p, logic [8:0] n, logic signed [4:0] t, bit keep);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.in_pos   = p;
    bus.in_neg   = n;
    bus.thresh   = t;
    while (!bus.in_ready && w < 40) begin @(negedge clk); w++; end
    if (!bus.in_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(string nm);
    int w = 0;
    while (!bus.out_valid && w < 40) begin @(negedge clk); w++; end
    if (!bus.out_valid) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic run10(logic [9:0] p, logic [9:0] n, output int d);
    int w = 0;
    bus10.in_pos   = p;
    bus10.in_neg   = n;
    bus10.in_valid = 1'b1;
    while (!bus10.in_ready && w < 40) begin @(negedge clk); w++; end
    @(negedge clk);
    bus10.in_valid = 1'b0;
    w = 0;
    while (!bus10.out_valid && w < 40) begin @(negedge clk); w++; end
    if (!bus10.out_valid) chk("n10_timeout", 0, 1);
    d = int'(bus10.out_diff);
    @(negedge clk);
  endtask

  initial begin
    int d1, d2;
    logic [4:0] bits;
    bus.in_valid = 1'b0; bus.in_pos = '0; bus.in_neg = '0; bus.thresh = '0; bus.out_ready = 1'b0;
    bus10.in_valid = 1'b0; bus10.in_pos = '0; bus10.in_neg = '0; bus10.thresh = '0;
    bus10.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_busy",     int'(bus.busy), 0);
    chk("rst_diff",     int'(bus.out_diff), 0);
    chk("rst_fire",     int'(bus.out_fire), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic transaction, then backpressure for 5 cycles
    send(9'h1FF, 9'h000, 5'sd5, 1'b0);
    wait_valid("basic");
    chk("basic_diff", int'(bus.out_diff), 9);
    chk("basic_fire", int'(bus.out_fire), int'(FIRE_EN));
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_pos = 9'h00F; bus.in_neg = 9'h000;
      chk("bp_in_ready",  int'(bus.in_ready), 0);
      chk("bp_out_valid", int'(bus.out_valid), 1);
      chk("bp_diff",      int'(bus.out_diff), 9);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_busy",     int'(bus.busy), 0);
    chk("bp_idle_in_ready", int'(bus.in_ready), 1);
    chk("bp_idle_valid",    int'(bus.out_valid), 0);
    chk("bp_no_accept",     sbq.size(), 0);

    // Negative result with MSB padding
    bus.out_ready = 1'b0;
    send(9'h001, 9'h1F0, 5'sd0, 1'b0);
    wait_valid("neg");
    bits = bus.out_diff;
    chk("neg_diff", int'(bus.out_diff), -4);
    chk("neg_bits", int'(bits), 28);
    chk("neg_fire", int'(bus.out_fire), 0);
    bus.out_ready = 1'b1;
    @(negedge clk);

    // Equal threshold
    send(9'h007, 9'h000, 5'sd3, 1'b0);
    wait_valid("eq");
    chk("eq_diff", int'(bus.out_diff), 3);
    chk("eq_fire", int'(bus.out_fire), int'(FIRE_EN));
    @(negedge clk);

    // Reset during NEG, then a fresh transaction
    send(9'h1FF, 9'h000, 5'sd0, 1'b0);
    repeat (4) @(negedge clk);
    chk("mid_busy_before", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_in_ready", int'(bus.in_ready), 1);
    chk("mid_valid",    int'(bus.out_valid), 0);
    chk("mid_busy",     int'(bus.busy), 0);
    rst = 1'b0;
    @(negedge clk);
    send(9'h0AA, 9'h101, 5'sd2, 1'b0);
    wait_valid("fresh");
    chk("fresh_diff", int'(bus.out_diff), 2);
    chk("fresh_fire", int'(bus.out_fire), int'(FIRE_EN));
    @(negedge clk);

    // N_IN=10: bit 9 of the negative vector lowers the result by one
    run10(10'h001, 10'h1F0, d1);
    run10(10'h001, 10'h3F0, d2);
    chk("n10_base",  d1, -4);
    chk("n10_bit9",  d2, -5);
    chk("n10_delta", d2 - d1, -1);

    // Back-to-back throughput
    rise_cyc.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      send(9'($urandom), 9'($urandom), 5'($urandom_range(0, 31)), i < 2);
    for (int w = 0; w < 40 && rise_cyc.size() < 3; w++) @(negedge clk);
    chk("b2b_count", rise_cyc.size(), 3);
    if (rise_cyc.size() >= 3) begin
      chk("b2b_gap1", rise_cyc[1] - rise_cyc[0], 8);
      chk("b2b_gap2", rise_cyc[2] - rise_cyc[1], 8);
    end
    repeat (3) @(negedge clk);
    chk("end_queue_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/popcount_ternary_seq.md
# popcount_ternary_seq

Sequential controller that time-shares a single exact 3-input popcount (full-adder) slice to evaluate one ternary neuron. Each transaction carries an N_IN-bit positive-weight match vector and an N_IN-bit negative-weight match vector. The block walks both vectors 3 bits per cycle through the shared slice and accumulates `pos_count - neg_count`. When threshold compare is compiled in, it also produces the neuron activation. It sits between the input-sampling front end and the layer output register in the printed NN datapath.

## Interface
Parameters:
- `N_IN`, default 9: bits per vector; 1..63.
- `K` (localparam): `ceil(N_IN/3)`, the number of chunks per vector.
- `CW` (localparam): `clog2(N_IN+1)`, the width of one unsigned count.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: input transaction offered.
- `in_ready`, out, 1: block can accept a transaction.
- `in_pos`, in, N_IN: positive-weight match bits.
- `in_neg`, in, N_IN: negative-weight match bits.
- `thresh`, in, CW+1: signed threshold, sampled at acceptance.
- `out_valid`, out, 1: result available.
- `out_ready`, in, 1: consumer takes the result.
- `out_diff`, out, CW+1: signed `pos_count - neg_count`.
- `out_fire`, out, 1: activation, `out_diff >= thresh` (signed).
- `busy`, out, 1: transaction in flight, i.e. state is not IDLE.

## Operation
- State machine: IDLE, POS, NEG, DONE.
- Reset values:
  - state = IDLE.
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `busy` = 0.
  - `out_diff` = 0.
  - `out_fire` = 0.
  - All accumulators and the chunk index = 0.
- **Reset mid-operation:** `rst` aborts any transaction. The in-flight result is discarded and never presented.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid && in_ready`, latch `in_pos`, `in_neg` and `thresh`. Zero-pad both vectors to 3K bits at the MSB end.
  - Clear both accumulators, set idx = 0, go to POS.
- **POS:**
  - Each cycle, feed bits `[3*idx+2 : 3*idx]` of the positive vector into the shared slice.
  - Add the 2-bit sum to `acc_pos` (CW bits, never overflows).
  - If idx == K-1: set idx = 0 and go to NEG. Otherwise idx++.
- **NEG:** same as POS, using the negative vector and `acc_neg`. At idx == K-1, register `out_diff = acc_pos - acc_neg_final`, sign-extended to CW+1, then go to DONE.
- **DONE:**
  - `out_valid` = 1.
  - `out_diff` and `out_fire` are held stable while `!out_ready`.
  - On `out_ready`, go to IDLE.
- `in_ready` = 0 in POS, NEG and DONE; there is no overlap between transactions.
- Input changes after acceptance have no effect.
- The shared slice is exactly one 3-input popcount: sum bit = XOR of the three bits, carry = majority. It is used by at most one chunk per cycle.

## Timing
- Acceptance edge E0 leaves IDLE.
- POS occupies edges E1..EK; NEG occupies edges EK+1..E2K.
- `out_valid` rises after edge E2K, i.e. 2K edges after acceptance (6 for N_IN=9).
- Fastest throughput is one transaction per 2K+2 cycles, with `out_ready` held at 1.
- **Back-to-back:** the `out_ready` edge returns to IDLE, and a new `in_valid` is accepted on the following edge.
- All outputs are registered or decoded from state only; there are no combinational paths from `in_*` or `out_ready` to any output.

## Configuration
- Macro: `POPCNT_TERN_THRESH_EN`.
- **Defined:** `thresh` is latched at acceptance and `out_fire` is registered alongside `out_diff`.
- **Undefined:**
  - `thresh` is ignored and no comparator is built.
  - `out_fire` is constant 0.
  - Cycle timing is unchanged.

## Test plan
All scenarios use N_IN=9, with `POPCNT_TERN_THRESH_EN` defined unless noted.
- **Reset mid-transaction.** Assert `rst` during NEG, release, then run a fresh transaction.
  - During reset: IDLE, `out_valid` = 0, `in_ready` = 1.
  - The fresh transaction's result is correct and uncontaminated by the aborted one.
- **Basic transaction.** `in_pos=9'h1FF`, `in_neg=9'h000`, `thresh=5`.
  - `out_valid` 6 edges after acceptance.
  - `out_diff=9`, `out_fire=1`.
- **Negative result and padding.** `in_pos=9'h001`, `in_neg=9'h1F0`, `thresh=0`.
  - `out_diff=-4` (CW+1=5 bits: 5'b11100), `out_fire=0`.
  - Repeat with N_IN=10 and bit 9 set in `in_neg` only: `out_diff=-1` relative to the same pattern without bit 9.
- **Backpressure.** `out_ready` held 0 for 5 cycles in DONE.
  - `out_valid`, `out_diff` and `out_fire` stay stable.
  - `in_ready` = 0 and a new `in_valid` is not accepted.
  - When `out_ready` rises: IDLE on the next edge.
- **Back-to-back throughput.** `out_ready` = 1 and `in_valid` = 1 continuously, 3 random transactions.
  - Results match the reference model.
  - Spacing between `out_valid` pulses is exactly 8 cycles.
- **Equal threshold, compare disabled.** `in_pos=9'h007`, `in_neg=9'h000`, `thresh=3`.
  - With the macro defined: `out_fire=1`.
  - Rebuilt without the macro: `out_fire=0`, `out_diff=3`, same latency.
